dec_2to4_3to8: RTL and testbench

Dual binary-to-one-hot decoder block: a 2-to-4 decoder and a 3-to-8 decoder sharing one active-high enable. Each decoder drives a combinational output and a registered copy with a valid flag. It serves as the address/select decode stage feeding chip-select and mux-select logic in the datapath.

---
 rtl/dec_2to4_3to8.sv | 42 ++++
 tb/tb_dec_2to4_3to8.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dec_2to4_3to8.sv
// Dual one-hot decoder (2->4 and 3->8) sharing one enable.
// Each decoder has a combinational result and a registered copy qualified by in_valid.
module dec_2to4_3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [1:0] in2,
  input  logic [2:0] in3,
  output logic [3:0] out2,
  output logic [7:0] out3,
  output logic [3:0] out2_q,
  output logic [7:0] out3_q,
  output logic       out_valid
);

  // With en low both results collapse to zero regardless of the selects.
  always_comb begin
    out2 = '0;
    out3 = '0;
    if (en) begin
      out2 = 4'b0001 << in2;
      out3 = 8'b0000_0001 << in3;
    end
  end

  // rst outranks in_valid; a capture on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out2_q    <= '0;
      out3_q    <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out2_q    <= out2;
      out3_q    <= out3;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_2to4_3to8.sv
// Directed self-checking bench for dec_2to4_3to8 using hand-computed vectors.
module tb_dec_2to4_3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [1:0] in2;
  logic [2:0] in3;
  logic [3:0] out2;
  logic [7:0] out3;
  logic [3:0] out2_q;
  logic [7:0] out3_q;
  logic       out_valid;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [3:0] exp2 [4];
  logic [7:0] exp3 [8];

  dec_2to4_3to8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in2      (in2),
    .in3      (in3),
    .out2     (out2),
    .out3     (out3),
    .out2_q   (out2_q),
    .out3_q   (out3_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp3 = '{8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
             8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000};

    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in2      = 2'd0;
    in3      = 3'd0;

    // Combinational sweeps, no clock edge needed.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in2 = 2'(i);
      #1;
      chk($sformatf("out2_sweep_%0d", i), {4'b0, out2}, {4'b0, exp2[i]});
    end
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(i);
      #1;
      chk($sformatf("out3_sweep_%0d", i), out3, exp3[i]);
    end

    // Enable gating.
    en  = 1'b0;
    in2 = 2'b11;
    in3 = 3'b101;
    #1;
    chk("out2_en_off", {4'b0, out2}, 8'h00);
    chk("out3_en_off", out3, 8'h00);
    en = 1'b1;
    #1;
    chk("out2_en_on", {4'b0, out2}, 8'b0000_1000);
    chk("out3_en_on", out3, 8'b0010_0000);

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out2_q", {4'b0, out2_q}, 8'h00);
    chk("rst_out3_q", out3_q, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);

    // Single capture.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in2 = 2'd2; in3 = 3'd6;
    @(posedge clk); #1;
    chk("cap_out2_q", {4'b0, out2_q}, 8'b0000_0100);
    chk("cap_out3_q", out3_q, 8'b0100_0000);
    chk("cap_valid", {7'b0, out_valid}, 8'h01);

    // Hold with in_valid low while selects change.
    @(negedge clk);
    in_valid = 1'b0; in2 = 2'd1; in3 = 3'd1;
    @(posedge clk); #1;
    chk("hold_out2_q", {4'b0, out2_q}, 8'b0000_0100);
    chk("hold_out3_q", out3_q, 8'b0100_0000);
    chk("hold_valid", {7'b0, out_valid}, 8'h00);

    // Back-to-back captures.
    @(negedge clk);
    in_valid = 1'b1; in2 = 2'd3; in3 = 3'd7;
    @(posedge clk); #1;
    chk("b2b1_out2_q", {4'b0, out2_q}, 8'b0000_1000);
    chk("b2b1_out3_q", out3_q, 8'b1000_0000);
    chk("b2b1_valid", {7'b0, out_valid}, 8'h01);
    @(negedge clk);
    in2 = 2'd0; in3 = 3'd1;
    @(posedge clk); #1;
    chk("b2b2_out2_q", {4'b0, out2_q}, 8'b0000_0001);
    chk("b2b2_out3_q", out3_q, 8'b0000_0010);
    chk("b2b2_valid", {7'b0, out_valid}, 8'h01);

    // Capture with enable off loads zeros but still flags valid.
    @(negedge clk);
    en = 1'b0; in2 = 2'd2; in3 = 3'd4;
    @(posedge clk); #1;
    chk("enoff_out2_q", {4'b0, out2_q}, 8'h00);
    chk("enoff_out3_q", out3_q, 8'h00);
    chk("enoff_valid", {7'b0, out_valid}, 8'h01);

    // Load non-zero, then reset with in_valid on the same edge.
    @(negedge clk);
    en = 1'b1; in2 = 2'd3; in3 = 3'd2;
    @(posedge clk); #1;
    chk("pre_rst_out3_q", out3_q, 8'b0000_0100);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in2 = 2'd1; in3 = 3'd3;
    #1;
    chk("rstprec_out2", {4'b0, out2}, 8'b0000_0010);
    chk("rstprec_out3", out3, 8'b0000_1000);
    @(posedge clk); #1;
    chk("rstprec_out2_q", {4'b0, out2_q}, 8'h00);
    chk("rstprec_out3_q", out3_q, 8'h00);
    chk("rstprec_valid", {7'b0, out_valid}, 8'h00);
    chk("rstprec_out2_comb", {4'b0, out2}, 8'b0000_0010);

    // First capture after reset release.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out2_q", {4'b0, out2_q}, 8'b0000_0010);
    chk("post_rst_out3_q", out3_q, 8'b0000_1000);
    chk("post_rst_valid", {7'b0, out_valid}, 8'h01);

    // Independence: in3 sweep must not disturb out2.
    @(negedge clk);
    in_valid = 1'b0;
    in2 = 2'd0;
    for (int i = 0; i < 8; i++) begin
      in3 = 3'(7 - i);
      #1;
      chk($sformatf("indep_out2_%0d", i), {4'b0, out2}, 8'b0000_0001);
      chk($sformatf("indep_out3_%0d", i), out3, exp3[7 - i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
